alu_wb_stage: RTL

- Sequential ALU execute/write-back stage directly upstream of the 16x32 data RAM.
- Accepts one operation per start pulse: opcode, two 32-bit operands, destination address.
- Computes single-cycle ops in one cycle and multiply iteratively.
- Drives the RAM write side (w_en, addr_w, s_ALU) and defers its write while the RAM read port is claimed, because the RAM gives r_en priority and drops a simultaneous write.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_mul_iter.sv | 55 +++++
 rtl/alu_wb_stage.sv | 108 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU execute/write-back stage and the
// RAM-side controller that sits next to it.
//   - WIDTH_DEF / ADDR_W_DEF : default data width and RAM address width
//   - OP_ADD .. OP_MUL       : 3-bit opcode values
//   - state_t                : write-back FSM state encoding
package alu_pkg;

    localparam int WIDTH_DEF  = 32;
    localparam int ADDR_W_DEF = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MUL   = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one multiplier bit
// per step, WIDTH steps per product. Only the low WIDTH bits are kept.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   load      : capture a (multiplicand) and b (multiplier), clear counter
//   step      : advance one bit
//   a, b      : operands, sampled on load
//   done      : high during the final step; prod is valid in that cycle
//   prod      : running sum including the current step's partial product
module alu_mul_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] prod
);

    localparam int CNT_W = $clog2(WIDTH);

    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] sum;
    logic [CNT_W-1:0] cnt;

    // Bits of mcand shifted past WIDTH only affect the discarded upper half.
    assign sum  = acc + (mplier[0] ? mcand : '0);
    assign prod = sum;
    assign done = step && (cnt == CNT_W'(WIDTH - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand  <= '0;
            mplier <= '0;
            acc    <= '0;
            cnt    <= '0;
        end else if (load) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
        end else if (step) begin
            acc    <= sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/alu_wb_stage.sv
// alu_wb_stage: ALU execute / write-back stage feeding the RAM write port.
// One operation per accepted start; single-cycle ops reach WRITE the next
// cycle, MUL goes through the iterative multiplier first. The write is held
// off while r_en is high because the RAM favours reads and would drop it.
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   start         : request, accepted only when idle
//   op, a, b, dest: opcode, operands, RAM destination (sampled on accept)
//   r_en          : RAM read claim this cycle; blocks the write
//   busy          : operation in flight
//   w_en          : RAM write enable / done strobe
//   addr_w, s_ALU : RAM write address and data
//   zero          : s_ALU == 0
module alu_wb_stage
    import alu_pkg::*;
#(
    parameter int WIDTH  = WIDTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        op,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    input  logic [ADDR_W-1:0] dest,
    input  logic              r_en,
    output logic              busy,
    output logic              w_en,
    output logic [ADDR_W-1:0] addr_w,
    output logic [WIDTH-1:0]  s_ALU,
    output logic              zero
);

    state_t           state;
    state_t           state_nxt;
    logic             accept;
    logic             mul_load;
    logic             mul_step;
    logic             mul_done;
    logic [WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0] alu_res;

    assign accept   = (state == ST_IDLE) && start;
    assign mul_load = accept && (op == OP_MUL);
    assign mul_step = (state == ST_MUL);

    assign busy = (state != ST_IDLE);
    assign w_en = (state == ST_WRITE) && !r_en;

    always_comb begin
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLL:  alu_res = a << b[4:0];
            OP_SRL:  alu_res = a >> b[4:0];
            default: alu_res = '0;
        endcase
    end

    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk  (clk),
        .rst  (rst),
        .load (mul_load),
        .step (mul_step),
        .a    (a),
        .b    (b),
        .done (mul_done),
        .prod (mul_prod)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = (op == OP_MUL) ? ST_MUL : ST_WRITE;
            ST_MUL:   if (mul_done) state_nxt = ST_WRITE;
            ST_WRITE: if (!r_en) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= ST_IDLE;
            addr_w <= '0;
            s_ALU  <= '0;
            zero   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_w <= dest;
                if (op != OP_MUL) begin
                    s_ALU <= alu_res;
                    zero  <= (alu_res == '0);
                end
            end
            if (mul_done) begin
                s_ALU <= mul_prod;
                zero  <= (mul_prod == '0);
            end
        end
    end

endmodule
